// File: rtl/hello_sim_ctrl_pkg.sv
// Shared definitions for the simulation control block: register offsets,
// controller FSM states and STATUS bit layout.
package hello_sim_ctrl_pkg;

  localparam logic [3:0] OFF_PUTCHAR = 4'h0;
  localparam logic [3:0] OFF_EXIT    = 4'h4;
  localparam logic [3:0] OFF_CYCLE   = 4'h8;
  localparam logic [3:0] OFF_STATUS  = 4'hC;

  localparam int STATUS_DONE_BIT    = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PUSH_WAIT = 2'd1,
    ST_RESP      = 2'd2
  } state_e;

  function automatic logic [31:0] status_word(input logic done, input logic timeout);
    logic [31:0] w;
    w = '0;
    w[STATUS_DONE_BIT]    = done;
    w[STATUS_TIMEOUT_BIT] = timeout;
    return w;
  endfunction

endpackage

// File: rtl/hello_char_fifo.sv
// Synchronous character FIFO with occupancy output; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module hello_char_fifo #(
  parameter int Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [7:0]               head_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL_LEVEL = Depth[AW:0];

  logic [7:0]  mem [Depth];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        pop_ok, push_ok;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == FULL_LEVEL);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Head reads as zero while empty so the console data is clean after reset.
  assign head_o  = empty_o ? 8'h00 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/hello_sim_ctrl.sv
// Simulation control peripheral: console character output, EXIT/watchdog
// status and a free-running cycle counter behind a valid/ready register port.
module hello_sim_ctrl
  import hello_sim_ctrl_pkg::*;
#(
  parameter int          FifoDepth     = 8,
  parameter logic [31:0] TimeoutCycles = 32'd50_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_addr_i,
  input  logic        req_write_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_data_o,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic        timeout_o
);

  localparam int LevelW = $clog2(FifoDepth) + 1;

  state_e            state_q, state_d;
  logic [3:0]        addr_word;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [7:0]        fifo_push_data, hold_q;
  logic [LevelW-1:0] fifo_level;
  logic              hold_load, rsp_load, exit_set, count_en;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d, cycle_q, exit_code_q;
  logic              rsp_error_q, rsp_error_d, done_q, timeout_q;

  assign addr_word    = req_addr_i & 4'b1100;
  assign fifo_pop     = char_valid_o && char_ready_i;
  assign char_valid_o = !fifo_empty;
  assign count_en     = !done_q && !timeout_q;

  assign req_ready_o  = (state_q == ST_IDLE);
  assign rsp_valid_o  = (state_q == ST_RESP);
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_error_o  = rsp_error_q;
  assign done_o       = done_q;
  assign exit_code_o  = exit_code_q;
  assign timeout_o    = timeout_q;

  always_comb begin
    state_d        = state_q;
    fifo_push      = 1'b0;
    fifo_push_data = req_wdata_i[7:0];
    hold_load      = 1'b0;
    rsp_load       = 1'b0;
    rsp_rdata_d    = '0;
    rsp_error_d    = 1'b0;
    exit_set       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          rsp_load = 1'b1;
          state_d  = ST_RESP;
          case (addr_word)
            OFF_PUTCHAR: begin
              if (!req_write_i) begin
                rsp_rdata_d = 32'(fifo_level);
              end else if (fifo_full && !fifo_pop) begin
                hold_load = 1'b1;
                state_d   = ST_PUSH_WAIT;
              end else begin
                fifo_push = 1'b1;
              end
            end
            OFF_EXIT: begin
              if (req_write_i) exit_set    = !done_q;
              else             rsp_rdata_d = exit_code_q;
            end
            OFF_CYCLE:  if (!req_write_i) rsp_rdata_d = cycle_q;
            OFF_STATUS: if (!req_write_i) rsp_rdata_d = status_word(done_q, timeout_q);
            default:    rsp_error_d = 1'b1;
          endcase
        end
      end
      ST_PUSH_WAIT: begin
        fifo_push_data = hold_q;
        if (!fifo_full || fifo_pop) begin
          fifo_push = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      done_q      <= 1'b0;
      exit_code_q <= '0;
      cycle_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rsp_load) begin
        rsp_rdata_q <= rsp_rdata_d;
        rsp_error_q <= rsp_error_d;
      end
      if (exit_set) begin
        done_q      <= 1'b1;
        exit_code_q <= req_wdata_i;
      end
      // Watchdog fires on the same edge the counter reaches the limit.
      if (count_en) begin
        cycle_q <= cycle_q + 32'd1;
        if (cycle_q + 32'd1 == TimeoutCycles) timeout_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (hold_load) hold_q <= req_wdata_i[7:0];
  end

  hello_char_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (char_data_o),
    .level_o     (fifo_level)
  );

endmodule

// File: tb/tb_hello_sim_ctrl.sv
// Directed bench for hello_sim_ctrl: console stream, FIFO back-pressure,
// EXIT handling, watchdog, response hold and reset during PUSH_WAIT.
module tb_hello_sim_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [3:0]  req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        char_valid_o;
  logic        char_ready_i = 1'b1;
  logic [7:0]  char_data_o;
  logic        done_o;
  logic [31:0] exit_code_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] char_q[$];

  always #5 clk_i = ~clk_i;

  hello_sim_ctrl #(
    .FifoDepth     (8),
    .TimeoutCycles (32'd100)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_write_i  (req_write_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_error_o  (rsp_error_o),
    .char_valid_o (char_valid_o),
    .char_ready_i (char_ready_i),
    .char_data_o  (char_data_o),
    .done_o       (done_o),
    .exit_code_o  (exit_code_o),
    .timeout_o    (timeout_o)
  );

  // Console sink: record every character handed over.
  always @(posedge clk_i) begin
    if (rst_ni && char_valid_o && char_ready_i) char_q.push_back(char_data_o);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at a falling edge; returns just after the accepting edge.
  task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wd);
    @(negedge clk_i);
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
  endtask

  task automatic txn(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic err);
    issue(wr, addr, wd);
    chk("rsp_latency1", 32'(rsp_valid_o), 32'd1);
    rd  = rsp_rdata_o;
    err = rsp_error_o;
    @(posedge clk_i); #1;
    chk("rsp_consumed", 32'(rsp_valid_o), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"},  32'(rsp_valid_o),  32'd0);
    chk({tag, "_rsp_rdata"},  rsp_rdata_o,       32'd0);
    chk({tag, "_rsp_error"},  32'(rsp_error_o),  32'd0);
    chk({tag, "_char_valid"}, 32'(char_valid_o), 32'd0);
    chk({tag, "_char_data"},  32'(char_data_o),  32'd0);
    chk({tag, "_done"},       32'(done_o),       32'd0);
    chk({tag, "_exit_code"},  exit_code_o,       32'd0);
    chk({tag, "_timeout"},    32'(timeout_o),    32'd0);
    chk({tag, "_req_ready"},  32'(req_ready_o),  32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          k;

    #2 rst_ni = 1'b0;
    #10;
    chk_reset_outputs("reset");
    @(negedge clk_i) rst_ni = 1'b1;

    // 'H','i' stream with a draining sink.
    txn(1'b1, 4'h0, 32'h48, rd, err);
    txn(1'b1, 4'h0, 32'h69, rd, err);
    @(posedge clk_i); #1;
    chk("hi_count", 32'(char_q.size()), 32'd2);
    if (char_q.size() == 2) begin
      chk("hi_char0", 32'(char_q[0]), 32'h48);
      chk("hi_char1", 32'(char_q[1]), 32'h69);
    end
    char_q.delete();

    // Fill the FIFO with the sink stalled; the ninth write must wait.
    char_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) txn(1'b1, 4'h0, 32'h41 + i, rd, err);
    txn(1'b0, 4'h0, 32'd0, rd, err);
    chk("level_full", rd, 32'd8);
    issue(1'b1, 4'h0, 32'h49);
    chk("push_wait_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("push_wait_not_ready", 32'(req_ready_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    chk("push_wait_still_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i) char_ready_i = 1'b1;
    @(posedge clk_i); #1;
    char_ready_i = 1'b0;
    chk("push_wait_rsp", 32'(rsp_valid_o), 32'd1);
    chk("push_wait_rdata", rsp_rdata_o, 32'd0);
    @(posedge clk_i); #1;
    chk("push_wait_consumed", 32'(rsp_valid_o), 32'd0);
    txn(1'b0, 4'h0, 32'd0, rd, err);
    chk("level_after_swap", rd, 32'd8);
    chk("level_err", 32'(err), 32'd0);
    chk("popped_count", 32'(char_q.size()), 32'd1);
    if (char_q.size() == 1) chk("popped_char", 32'(char_q[0]), 32'h41);
    chk("char_head", 32'(char_data_o), 32'h42);

    // EXIT: first write wins.
    txn(1'b1, 4'h4, 32'h0, rd, err);
    chk("exit0_done", 32'(done_o), 32'd1);
    chk("exit0_code", exit_code_o, 32'd0);
    chk("exit0_rdata", rd, 32'd0);
    txn(1'b1, 4'h4, 32'h5, rd, err);
    chk("exit5_done", 32'(done_o), 32'd1);
    chk("exit5_code_kept", exit_code_o, 32'd0);
    txn(1'b0, 4'hC, 32'd0, rd, err);
    chk("status_done", rd, 32'h1);
    txn(1'b0, 4'h4, 32'd0, rd, err);
    chk("exit_read", rd, 32'd0);

    // Reset while stalled in PUSH_WAIT (FIFO still full, sink stalled).
    issue(1'b1, 4'h0, 32'h5A);
    chk("pw2_no_rsp", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i) rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk_i) rst_ni = 1'b1;
    char_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_release", 32'(req_ready_o), 32'd1);
    chk("fifo_empty_after_reset", 32'(char_valid_o), 32'd0);

    // Watchdog: counter is 1 here, timeout must rise exactly at 100.
    k = 1;
    while (!timeout_o && k < 200) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("timeout_set", 32'(timeout_o), 32'd1);
    chk("timeout_cycle", 32'(k), 32'd100);
    txn(1'b0, 4'h8, 32'd0, rd, err);
    chk("cycle_frozen", rd, 32'd100);
    txn(1'b0, 4'hB, 32'd0, rd, err);
    chk("cycle_alias_low_bits", rd, 32'd100);
    chk("cycle_alias_err", 32'(err), 32'd0);

    // Response must hold while the consumer stalls.
    rsp_ready_i = 1'b0;
    issue(1'b0, 4'hC, 32'd0);
    chk("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_rdata", rsp_rdata_o, 32'h2);
      chk("hold_error", 32'(rsp_error_o), 32'd0);
      chk("hold_not_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("hold_released", 32'(rsp_valid_o), 32'd0);

    // EXIT after timeout still completes.
    txn(1'b1, 4'h4, 32'h7, rd, err);
    chk("late_exit_done", 32'(done_o), 32'd1);
    chk("late_exit_code", exit_code_o, 32'h7);
    txn(1'b0, 4'hC, 32'd0, rd, err);
    chk("status_both", rd, 32'h3);
    txn(1'b1, 4'h8, 32'hFFFF, rd, err);
    chk("cycle_write_no_err", 32'(err), 32'd0);
    txn(1'b0, 4'h8, 32'd0, rd, err);
    chk("cycle_still_100", rd, 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
